// File: rtl/stream_multiplier_rt_if.sv
// Stream bundle for the runtime-length big-number multiplier: operand beats in, product beats out.
// Ports: num_blocks_in/square_in/n_in/m_in/valid_in/ready_out form the operand stream;
//        data_out/valid_out/final_out/consumer_ready_in form the product stream; busy_out is status.
interface stream_multiplier_rt_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int MAX_BITS      = 2048,
  parameter int MAX_BLOCKS    = MAX_BITS / REGISTER_SIZE,
  parameter int LEN_WIDTH     = $clog2(MAX_BLOCKS) + 1
);
  logic [LEN_WIDTH-1:0]     num_blocks_in;
  logic                     square_in;
  logic [REGISTER_SIZE-1:0] n_in;
  logic [REGISTER_SIZE-1:0] m_in;
  logic                     valid_in;
  logic                     ready_out;
  logic [REGISTER_SIZE-1:0] data_out;
  logic                     valid_out;
  logic                     consumer_ready_in;
  logic                     final_out;
  logic                     busy_out;

  // Side that drives operands and consumes the product.
  modport master (
    output num_blocks_in, square_in, n_in, m_in, valid_in, consumer_ready_in,
    input  ready_out, data_out, valid_out, final_out, busy_out
  );

  // The multiplier itself.
  modport slave (
    input  num_blocks_in, square_in, n_in, m_in, valid_in, consumer_ready_in,
    output ready_out, data_out, valid_out, final_out, busy_out
  );
endinterface

// File: rtl/stream_multiplier_rt.sv
// Schoolbook multiplier of two L-block operands (L chosen per operation) giving a 2L-block product.
// Latency: L load beats + 2L clear cycles + L*(L+1) compute cycles, then 2L output beats.
// Backpressure: ready_out low outside IDLE/LOAD; output beats hold stable while consumer_ready_in is low.
// Ports: clk_in, rst_in (synchronous, active low), bus (slave modport of stream_multiplier_rt_if).
module stream_multiplier_rt #(
  parameter int REGISTER_SIZE = 32,
  parameter int MAX_BITS      = 2048,
  parameter int MAX_BLOCKS    = MAX_BITS / REGISTER_SIZE,
  parameter int LEN_WIDTH     = $clog2(MAX_BLOCKS) + 1
) (
  input logic                   clk_in,
  input logic                   rst_in,
  stream_multiplier_rt_if.slave bus
);

  localparam int W  = REGISTER_SIZE;
  localparam int NW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int AW = $clog2(2 * MAX_BLOCKS);
  localparam logic [LEN_WIDTH-1:0] MAXB = LEN_WIDTH'(MAX_BLOCKS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    COMPUTE,
    OUTPUT
  } state_t;

  logic [W-1:0] n_mem [MAX_BLOCKS];
  logic [W-1:0] m_mem [MAX_BLOCKS];
  logic [W-1:0] acc   [2*MAX_BLOCKS];

  state_t               state;
  logic [LEN_WIDTH-1:0] len;
  logic                 sq;
  logic [NW-1:0]        load_idx;
  logic [AW-1:0]        idx;          // shared by CLEAR and OUTPUT sweeps
  logic [LEN_WIDTH-1:0] i_idx;        // runs 0..L, L being the carry-flush pass
  logic [NW-1:0]        j_idx;
  logic [W-1:0]         prev_upper;
  logic                 prod_carry;
  logic                 acc_carry;

  logic                 in_accept;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [LEN_WIDTH:0]   two_l;
  logic [AW-1:0]        last_word;
  logic                 last_load;
  logic                 last_i;
  logic                 last_j;
  logic [AW-1:0]        acc_addr;
  logic [W-1:0]         n_blk;
  logic [W-1:0]         m_blk;
  logic [2*W-1:0]       prod;
  logic [W:0]           word_sum;
  logic [W:0]           acc_sum;

  assign in_accept = bus.valid_in && bus.ready_out;

  always_comb begin
    len_eff = bus.num_blocks_in;
    if (bus.num_blocks_in == '0 || bus.num_blocks_in > MAXB) begin
      len_eff = MAXB;
    end
  end

  assign two_l     = {len, 1'b0};
  assign last_word = AW'(two_l - 1'b1);
  assign last_load = (LEN_WIDTH'(load_idx) == len - 1'b1);
  assign last_i    = (i_idx == len);
  assign last_j    = (LEN_WIDTH'(j_idx) == len - 1'b1);
  assign acc_addr  = AW'(i_idx) + AW'(j_idx);

  // One full read-modify-write of acc[i+j] per cycle: the read and the write of a
  // word happen in the same cycle, so the next step always sees the updated value.
  always_comb begin
    n_blk    = last_i ? '0 : n_mem[i_idx[NW-1:0]];
    m_blk    = m_mem[j_idx];
    prod     = {{W{1'b0}}, n_blk} * {{W{1'b0}}, m_blk};
    word_sum = {1'b0, prod[W-1:0]} + {1'b0, prev_upper} + (W+1)'(prod_carry);
    acc_sum  = {1'b0, acc[acc_addr]} + {1'b0, word_sum[W-1:0]} + (W+1)'(acc_carry);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      bus.ready_out <= 1'b1;
      bus.valid_out <= 1'b0;
      bus.final_out <= 1'b0;
      bus.busy_out  <= 1'b0;
      bus.data_out  <= '0;
      len           <= '0;
      sq            <= 1'b0;
      load_idx      <= '0;
      idx           <= '0;
      i_idx         <= '0;
      j_idx         <= '0;
      prev_upper    <= '0;
      prod_carry    <= 1'b0;
      acc_carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_accept) begin
            len          <= len_eff;
            sq           <= bus.square_in;
            n_mem[0]     <= bus.n_in;
            m_mem[0]     <= bus.square_in ? bus.n_in : bus.m_in;
            load_idx     <= NW'(1);
            idx          <= '0;
            bus.busy_out <= 1'b1;
            if (len_eff == LEN_WIDTH'(1)) begin
              state         <= CLEAR;
              bus.ready_out <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (in_accept) begin
            n_mem[load_idx] <= bus.n_in;
            m_mem[load_idx] <= sq ? bus.n_in : bus.m_in;
            load_idx        <= load_idx + 1'b1;
            if (last_load) begin
              state         <= CLEAR;
              bus.ready_out <= 1'b0;
            end
          end
        end

        // Zeroing here, not at the end of an operation, keeps the accumulator
        // clean even when the previous operation was cut short by reset.
        CLEAR: begin
          acc[idx] <= '0;
          idx      <= idx + 1'b1;
          if (idx == last_word) begin
            state      <= COMPUTE;
            i_idx      <= '0;
            j_idx      <= '0;
            prev_upper <= '0;
            prod_carry <= 1'b0;
            acc_carry  <= 1'b0;
          end
        end

        COMPUTE: begin
          acc[acc_addr] <= acc_sum[W-1:0];
          if (last_i) begin
            // Row j finished: carries never cross rows.
            i_idx      <= '0;
            prev_upper <= '0;
            prod_carry <= 1'b0;
            acc_carry  <= 1'b0;
            if (last_j) begin
              // The final step writes acc[2L-1], never acc[0], so word 0 is settled.
              state         <= OUTPUT;
              idx           <= '0;
              bus.data_out  <= acc[0];
              bus.valid_out <= 1'b1;
              bus.final_out <= 1'b0;
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end else begin
            i_idx      <= i_idx + 1'b1;
            prev_upper <= prod[2*W-1:W];
            prod_carry <= word_sum[W];
            acc_carry  <= acc_sum[W];
          end
        end

        OUTPUT: begin
          if (bus.consumer_ready_in) begin
            if (bus.final_out) begin
              state         <= IDLE;
              bus.valid_out <= 1'b0;
              bus.final_out <= 1'b0;
              bus.ready_out <= 1'b1;
              bus.busy_out  <= 1'b0;
              bus.data_out  <= '0;
            end else begin
              idx           <= idx + 1'b1;
              bus.data_out  <= acc[idx + 1'b1];
              bus.final_out <= ((idx + 1'b1) == last_word);
            end
          end
        end

        default: begin
          state         <= IDLE;
          bus.ready_out <= 1'b1;
          bus.valid_out <= 1'b0;
          bus.final_out <= 1'b0;
          bus.busy_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_multiplier_rt.sv
// Bench for stream_multiplier_rt: scoreboard of expected product beats fed by a
// big-number reference model, with an independent monitor popping on each transfer.
module tb_stream_multiplier_rt;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_multiplier_rt_if bus_if ();

  stream_multiplier_rt dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [W-1:0] d;
    bit           f;
  } exp_t;

  exp_t         exp_q[$];
  int           checks   = 0;
  int           errors   = 0;
  int           ops_done = 0;
  int           busy_bad = 0;
  bit           cr_rand  = 1'b0;
  logic [W-1:0] op_n[64];
  logic [W-1:0] op_m[64];

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic check_reset();
    chk("rst_ready", 64'(bus_if.ready_out), 64'd1);
    chk("rst_valid", 64'(bus_if.valid_out), 64'd0);
    chk("rst_final", 64'(bus_if.final_out), 64'd0);
    chk("rst_busy",  64'(bus_if.busy_out),  64'd0);
    chk("rst_data",  64'(bus_if.data_out),  64'd0);
  endtask

  // Reference: textbook long multiplication, n-row outer loop with a 64-bit running carry.
  task automatic push_model(int len, bit sq);
    logic [W-1:0]    r[128];
    logic [W-1:0]    mv;
    longint unsigned t;
    longint unsigned carry;
    for (int k = 0; k < 2 * len; k++) r[k] = '0;
    for (int i = 0; i < len; i++) begin
      carry = 0;
      for (int j = 0; j < len; j++) begin
        mv    = sq ? op_n[j] : op_m[j];
        t     = 64'(r[i+j]) + 64'(op_n[i]) * 64'(mv) + carry;
        r[i+j] = t[31:0];
        carry = t >> 32;
      end
      r[i+len] = carry[31:0];
    end
    for (int k = 0; k < 2 * len; k++) exp_q.push_back('{d: r[k], f: (k == 2 * len - 1)});
  endtask

  task automatic push_lit(logic [W-1:0] v, bit f);
    exp_q.push_back('{d: v, f: f});
  endtask

  // Entered and left at posedge+1. Feeds len beats, optionally with valid_in gaps.
  task automatic send_op(int lfield, int len, bit sq, bit gappy);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    busy_bad = 0;
    while (k < len && cyc < 1000) begin
      bus_if.valid_in      = gappy ? (cyc % 2 == 0) : 1'b1;
      bus_if.num_blocks_in = 7'(lfield);
      bus_if.square_in     = sq;
      bus_if.n_in          = op_n[k];
      bus_if.m_in          = sq ? 32'hDEADBEEF : op_m[k];
      @(negedge clk);
      acc = bus_if.valid_in && bus_if.ready_out;
      if (k > 0 && !bus_if.busy_out) busy_bad++;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    bus_if.valid_in = 1'b0;
    if (k < len) begin
      errors++;
      $display("FAIL load_timeout accepted=%0d required=%0d", k, len);
    end
  endtask

  // Wait for the final beat to be transferred, then look at the idle state.
  task automatic wait_done(int bound);
    int target = ops_done + 1;
    int cyc = 0;
    while (ops_done < target && cyc < bound) begin
      @(negedge clk);
      #1;
      if (ops_done < target && !bus_if.busy_out) busy_bad++;
      cyc++;
    end
    if (ops_done < target) begin
      errors++;
      $display("FAIL op_timeout completed=%0d required=%0d", ops_done, target);
    end else begin
      chk("busy_held", 64'(busy_bad), 64'd0);
      @(posedge clk);
      #1;
      chk("idle_ready", 64'(bus_if.ready_out), 64'd1);
      chk("idle_busy",  64'(bus_if.busy_out),  64'd0);
      chk("idle_valid", 64'(bus_if.valid_out), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  // Consumer: always ready, or a coin toss each cycle.
  initial begin
    bus_if.consumer_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.consumer_ready_in = cr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: every presented beat must equal the scoreboard head, stalled or not.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat data=%h final=%b expected no beat",
                   bus_if.data_out, bus_if.final_out);
        end else begin
          if (bus_if.data_out !== exp_q[0].d || bus_if.final_out !== exp_q[0].f) begin
            errors++;
            $display("FAIL beat data=%h final=%b expected data=%h final=%b",
                     bus_if.data_out, bus_if.final_out, exp_q[0].d, exp_q[0].f);
          end
          if (bus_if.consumer_ready_in) begin
            if (exp_q[0].f) ops_done++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int len;
    int lf;
    bit sq;
    bus_if.valid_in      = 1'b0;
    bus_if.num_blocks_in = '0;
    bus_if.square_in     = 1'b0;
    bus_if.n_in          = '0;
    bus_if.m_in          = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single block, all ones
    op_n[0] = 32'hFFFFFFFF; op_m[0] = 32'hFFFFFFFF;
    push_lit(32'h00000001, 1'b0);
    push_lit(32'hFFFFFFFE, 1'b1);
    send_op(1, 1, 1'b0, 1'b0);
    wait_done(200);

    // 2: two blocks, carry chain
    for (int k = 0; k < 2; k++) begin op_n[k] = '1; op_m[k] = '1; end
    push_lit(32'h00000001, 1'b0);
    push_lit(32'h00000000, 1'b0);
    push_lit(32'hFFFFFFFE, 1'b0);
    push_lit(32'hFFFFFFFF, 1'b1);
    send_op(2, 2, 1'b0, 1'b0);
    wait_done(200);

    // 3: squaring ignores m_in
    op_n[0] = 32'd3; op_n[1] = 32'd0;
    push_lit(32'd9, 1'b0);
    push_lit(32'd0, 1'b0);
    push_lit(32'd0, 1'b0);
    push_lit(32'd0, 1'b1);
    send_op(2, 2, 1'b1, 1'b0);
    wait_done(200);

    // 4: L=4 random with load gaps and output stalls
    cr_rand = 1'b1;
    for (int k = 0; k < 4; k++) begin op_n[k] = $urandom; op_m[k] = $urandom; end
    push_model(4, 1'b0);
    send_op(4, 4, 1'b0, 1'b1);
    wait_done(500);

    // 5: abort an L=64 op mid-compute, then a small op must be clean
    cr_rand = 1'b0;
    for (int k = 0; k < 64; k++) begin op_n[k] = '1; op_m[k] = '1; end
    send_op(64, 64, 1'b0, 1'b0);
    repeat (128 + 600) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op_n[0] = 32'd5; op_n[1] = 32'd0; op_m[0] = 32'd7; op_m[1] = 32'd0;
    push_lit(32'd35, 1'b0);
    push_lit(32'd0, 1'b0);
    push_lit(32'd0, 1'b0);
    push_lit(32'd0, 1'b1);
    send_op(2, 2, 1'b0, 1'b0);
    wait_done(200);

    // 6: num_blocks_in == 0 means 64 blocks
    cr_rand = 1'b1;
    for (int k = 0; k < 64; k++) begin op_n[k] = $urandom; op_m[k] = $urandom; end
    push_model(64, 1'b0);
    send_op(0, 64, 1'b0, 1'b0);
    wait_done(20000);

    // Oversized length clamps to 64, in squaring mode
    for (int k = 0; k < 64; k++) op_n[k] = $urandom;
    lf = $urandom_range(65, 127);
    push_model(64, 1'b1);
    send_op(lf, 64, 1'b1, 1'b1);
    wait_done(20000);

    // Back-to-back short ops with mixed length and mode
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 6);
      sq  = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < len; k++) begin op_n[k] = $urandom; op_m[k] = $urandom; end
      if (t % 3 == 0) op_n[0] = '1;
      push_model(len, sq);
      send_op(len, len, sq, ($urandom_range(0, 1) == 1));
      wait_done(500);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_multiplier_rt.md
Name: stream_multiplier_rt

Overview:
Runtime-length, parametrised schoolbook big-number multiplier for the encryption datapath. It accepts two operands streamed one REGISTER_SIZE-bit block per beat, LSB block first, and computes the full double-width product. It streams the product back out with consumer backpressure. Compared with the fixed-length multiplier, it adds a per-operation operand length, a squaring mode, an input stall tolerance, an output stall tolerance, and a guaranteed-clean accumulator after an abort.

Parameters:
REGISTER_SIZE, 32, block width in bits.
MAX_BITS, 2048, largest operand width supported.
MAX_BLOCKS, MAX_BITS/REGISTER_SIZE, derived; maximum operand length in blocks.
LEN_WIDTH, $clog2(MAX_BLOCKS)+1, derived; width of the length input.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  synchronous, active-low reset.
num_blocks_in  input  LEN_WIDTH  operand length L in blocks; sampled on the first accepted beat.
square_in  input  1  squaring mode; sampled on the first accepted beat; when 1, m_in is ignored and m := n.
n_in  input  REGISTER_SIZE  operand n block.
m_in  input  REGISTER_SIZE  operand m block.
valid_in  input  1  the input block pair is valid.
ready_out  output  1  the block can accept input (high in IDLE and LOAD).
data_out  output  REGISTER_SIZE  product block, LSB first.
valid_out  output  1  data_out is valid.
consumer_ready_in  input  1  downstream accepts data_out this cycle.
final_out  output  1  high with the last product block (index 2L-1).
busy_out  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_in == 0 at a clock edge):
  - State goes to IDLE.
  - valid_out, final_out and busy_out go to 0; ready_out goes to 1; data_out goes to 0.
  - Reset mid-operation discards the operation. No partial output beat is emitted after reset.
- Handshakes:
  - An input beat is accepted when valid_in && ready_out.
  - An output beat is transferred when valid_out && consumer_ready_in.
- Length:
  - L = num_blocks_in, sampled on the first accepted beat.
  - num_blocks_in == 0 or num_blocks_in > MAX_BLOCKS is treated as MAX_BLOCKS.
- IDLE:
  - On the first accepted beat: latch L and square_in, store block 0, then go to LOAD, or directly to CLEAR if L == 1.
- LOAD:
  - Each accepted beat stores the next block.
  - valid_in low stalls the load; the operation is not aborted.
  - After L beats have been accepted, ready_out drops on the next cycle and the state goes to CLEAR.
- CLEAR:
  - Zero accumulator words 0..2L-1, one word per cycle. This takes 2L cycles.
  - Then go to COMPUTE.
  - The accumulator is therefore always clean at COMPUTE entry, even after a reset or abort.
- COMPUTE:
  - For j = 0..L-1: for i = 0..L (the i == L pass uses a zero n block to flush carries).
  - Each step forms the 2*REGISTER_SIZE-bit product n[i]*m[j], with lower/upper split.
  - Word sum: lower + previous upper + product carry.
  - Accumulator update: acc[i+j] += that word sum + accumulator carry.
  - Carries are one bit each; both carries are zeroed at the start of each j.
  - The pipeline has an internal read-modify-write hazard at acc[i+j]; the implementation must keep it hazard-free.
  - Total COMPUTE cycles ≤ L*(L+1) + 8.
- OUTPUT:
  - Present acc[0..2L-1] in order with valid_out = 1.
  - data_out, valid_out and final_out hold stable while consumer_ready_in == 0.
  - final_out = 1 only on index 2L-1.
  - After the final beat is transferred, the state goes to IDLE on the next cycle: ready_out = 1, busy_out = 0.
  - valid_out is never high outside OUTPUT.
- Arithmetic:
  - The product is exact and modulo-free: 2L blocks, with the upper blocks zero-padded as the result dictates.
  - Widths internal to the adders are REGISTER_SIZE+1 bits.
- Simultaneous events:
  - valid_in asserted during CLEAR, COMPUTE or OUTPUT is ignored (ready_out is 0).
  - Reset overrides any handshake in the same cycle.
- Throughput:
  - A new first beat is accepted in the cycle after final_out is transferred.
  - Back-to-back operations with differing L and square_in must not interfere.

Test Plan:
1. L=1, n=0xFFFFFFFF, m=0xFFFFFFFF, consumer_ready_in=1 -> output 0x00000001 then 0xFFFFFFFE; final_out on the 2nd beat.
2. L=2, n=m={0xFFFFFFFF,0xFFFFFFFF} (carry chain) -> output 0x00000001, 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF; final_out only on the 4th beat.
3. square_in=1, L=2, n={0x00000003,0x00000000}, m_in=0xDEADBEEF garbage -> output 9, 0, 0, 0.
4. L=4 random operands, with valid_in deasserted every other cycle during LOAD and consumer_ready_in toggled pseudo-randomly -> 8 blocks match the reference model; output is held stable while stalled; no duplicated or dropped blocks.
5. Start an L=64 op with all-ones operands, pulse rst_in=0 mid-COMPUTE, then run L=2 with n={5,0}, m={7,0} -> outputs 35, 0, 0, 0; no output beats before the second op.
6. num_blocks_in=0 with 64 random block pairs -> treated as L=64; 128 output blocks match the model; busy_out stays high from the first beat until after final_out.
